// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEFAULT  = 64;
  localparam int unsigned INSTR_W_DEFAULT = 32;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_preg.sv
// Fetch/decode pipeline register: flush beats stall, stall beats load, otherwise a bubble.
module preg_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = ADDR_W_DEFAULT,
  parameter int unsigned INSTR_WIDTH = INSTR_W_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_load,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
  output logic                   o_valid
);

  localparam logic [INSTR_WIDTH-1:0] NOP      = INSTR_WIDTH'(NOP_INSTR);
  localparam logic [ADDR_WIDTH-1:0]  PC_STEP  = ADDR_WIDTH'(4);

  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  pc4_q, pc4_d;
  logic                   valid_q, valid_d;

  // Bubbles keep the PC fields so decode-side debug still sees the last address.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (i_flush) begin
      valid_d = 1'b0;
      instr_d = NOP;
    end else if (i_stall) begin
      valid_d = valid_q;
    end else if (i_load) begin
      valid_d = 1'b1;
      instr_d = i_instr;
      pc_d    = i_pc;
      pc4_d   = i_pc + PC_STEP;
    end else begin
      valid_d = 1'b0;
      instr_d = NOP;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      instr_q <= NOP;
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign o_instruction = instr_q;
  assign o_pc          = pc_q;
  assign o_pc_plus4    = pc4_q;
  assign o_valid       = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: single-outstanding imem requests, one-entry stall buffer, redirect squash.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = ADDR_W_DEFAULT,
  parameter int unsigned           INSTR_WIDTH = INSTR_W_DEFAULT,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_stallF,
  input  logic                   i_stallD,
  input  logic                   i_flushD,
  input  logic                   i_redirect,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  output logic                   o_imem_req_valid,
  input  logic                   i_imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  o_imem_addr,
  input  logic                   i_imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] i_imem_rsp_data,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
  output logic                   o_valid
);

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_AL = {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
  localparam logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(4);

  fetch_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
  logic                   req_pend_q, req_pend_d;
  logic                   redir_seen_q, redir_seen_d;
  logic                   buf_valid_q, buf_valid_d;
  logic [INSTR_WIDTH-1:0] buf_instr_q, buf_instr_d;
  logic [ADDR_WIDTH-1:0]  buf_pc_q, buf_pc_d;

  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic                   req_valid;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic                   req_fire;
  logic                   rsp_accept;
  logic                   buf_drain;
  logic                   dec_load;
  logic [INSTR_WIDTH-1:0] dec_instr;
  logic [ADDR_WIDTH-1:0]  dec_pc;
  logic                   unused_redirect_lsb;

  assign unused_redirect_lsb = ^i_redirect_pc[1:0];

  // Handshake qualifiers; a request once raised stays put until the memory takes it.
  always_comb begin
    redirect_pc = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    req_valid   = i_rstn && (state_q == S_REQ) &&
                  (req_pend_q || (!buf_valid_q && !i_stallF));
    req_addr    = req_pend_q ? req_addr_q : pc_q;
    req_fire    = req_valid && i_imem_req_ready;
    rsp_accept  = (state_q == S_WAIT) && i_imem_rsp_valid && !i_redirect;
    buf_drain   = buf_valid_q && !i_stallD && !i_flushD && !i_redirect;
    dec_load    = buf_drain || (rsp_accept && !i_stallD && !i_flushD);
    dec_instr   = buf_valid_q ? buf_instr_q : i_imem_rsp_data;
    dec_pc      = buf_valid_q ? buf_pc_q : req_addr_q;
  end

  // Next-state logic; redirect is applied last so it overrides the PC and buffer.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    req_pend_d   = req_pend_q;
    redir_seen_d = redir_seen_q;
    buf_valid_d  = buf_valid_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;

    unique case (state_q)
      S_REQ: begin
        if (req_fire) begin
          state_d      = (i_redirect || redir_seen_q) ? S_DROP : S_WAIT;
          req_addr_d   = req_addr;
          req_pend_d   = 1'b0;
          redir_seen_d = 1'b0;
        end else if (req_valid) begin
          req_pend_d = 1'b1;
          req_addr_d = req_addr;
          if (i_redirect) begin
            redir_seen_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (i_imem_rsp_valid) begin
          state_d = S_REQ;
          pc_d    = req_addr_q + PC_STEP;
        end else if (i_redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (i_imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (buf_drain) begin
      buf_valid_d = 1'b0;
    end
    if (rsp_accept && (i_stallD || i_flushD)) begin
      buf_valid_d = 1'b1;
      buf_instr_d = i_imem_rsp_data;
      buf_pc_d    = req_addr_q;
    end

    if (i_redirect) begin
      pc_d        = redirect_pc;
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC_AL;
      req_addr_q   <= RESET_PC_AL;
      req_pend_q   <= 1'b0;
      redir_seen_q <= 1'b0;
      buf_valid_q  <= 1'b0;
      buf_instr_q  <= INSTR_WIDTH'(NOP_INSTR);
      buf_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      req_pend_q   <= req_pend_d;
      redir_seen_q <= redir_seen_d;
      buf_valid_q  <= buf_valid_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
    end
  end

  assign o_imem_req_valid = req_valid;
  assign o_imem_addr      = req_addr;

  preg_fetch #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_preg (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_stall       (i_stallD),
    .i_flush       (i_flushD),
    .i_load        (dec_load),
    .i_instr       (dec_instr),
    .i_pc          (dec_pc),
    .o_instruction (o_instruction),
    .o_pc          (o_pc),
    .o_pc_plus4    (o_pc_plus4),
    .o_valid       (o_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, mid-operation reset, randomized run vs. reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn, stall_f, stall_d, flush_d, redir, ready, rsp_v;
  logic [63:0] rpc;
  logic [31:0] rsp_d;

  logic        req_v, b_req;
  logic [63:0] addr, b_addr, pc, b_pc, pc4, b_pc4;
  logic [31:0] instr, b_instr;
  logic        valid, b_valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .i_clk(clk), .i_rstn(rstn), .i_stallF(stall_f), .i_stallD(stall_d), .i_flushD(flush_d),
    .i_redirect(redir), .i_redirect_pc(rpc), .o_imem_req_valid(req_v), .i_imem_req_ready(ready),
    .o_imem_addr(addr), .i_imem_rsp_valid(rsp_v), .i_imem_rsp_data(rsp_d),
    .o_instruction(instr), .o_pc(pc), .o_pc_plus4(pc4), .o_valid(valid)
  );

  fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_b (
    .i_clk(clk), .i_rstn(rstn), .i_stallF(stall_f), .i_stallD(stall_d), .i_flushD(flush_d),
    .i_redirect(redir), .i_redirect_pc(rpc), .o_imem_req_valid(b_req), .i_imem_req_ready(ready),
    .o_imem_addr(b_addr), .i_imem_rsp_valid(rsp_v), .i_imem_rsp_data(rsp_d),
    .o_instruction(b_instr), .o_pc(b_pc), .o_pc_plus4(b_pc4), .o_valid(b_valid)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tag(input int k);
    return 32'hC000_0000 | 32'(k);
  endfunction

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
  endfunction

  typedef struct {
    logic        ready, rsp, sd, fd, rd;
    logic [63:0] rpc;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic        exp_v;
    logic [63:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(input logic rdy, input logic rs, input logic sd, input logic fd,
                              input logic rd, input logic [63:0] tgt, input logic er,
                              input logic [63:0] ea, input logic ev, input logic [63:0] ep,
                              input logic [31:0] ei);
    vec_t v;
    v.ready = rdy; v.rsp = rs; v.sd = sd; v.fd = fd; v.rd = rd; v.rpc = tgt;
    v.exp_req = er; v.exp_addr = ea; v.exp_v = ev; v.exp_pc = ep; v.exp_instr = ei;
    return v;
  endfunction

  // Reference model state: in-flight requests, hold buffer and decode register contents.
  typedef struct { logic [63:0] addr; bit drop; } fl_t;
  typedef struct { logic [31:0] instr; logic [63:0] pc; } ent_t;
  fl_t         m_fl[$];
  ent_t        m_buf[$];
  logic [63:0] m_pc, m_pend_addr, m_dp, m_dp4;
  logic [31:0] m_di;
  bit          m_pend, m_seen, m_dv;
  bit          e_req;
  logic [63:0] e_addr;

  task automatic model_reset();
    m_fl.delete(); m_buf.delete();
    m_pc = 64'h0; m_pend = 0; m_seen = 0; m_pend_addr = 64'h0;
    m_dv = 0; m_di = NOP; m_dp = 64'h0; m_dp4 = 64'h0;
  endtask

  task automatic model_comb();
    e_req  = rstn && (m_fl.size() == 0) && (m_pend || (m_buf.size() == 0 && !stall_f));
    e_addr = m_pend ? m_pend_addr : m_pc;
  endtask

  task automatic model_step();
    bit   got, had_buf;
    ent_t g, e;
    fl_t  t;
    got = 0;
    if (!rstn) begin
      model_reset();
      return;
    end
    if (rsp_v && m_fl.size() > 0) begin
      t = m_fl.pop_front();
      if (!t.drop && !redir) begin
        got = 1; g.instr = mem_data(t.addr); g.pc = t.addr; m_pc = t.addr + 64'd4;
      end
    end
    if (e_req && ready) begin
      t.addr = e_addr; t.drop = redir || m_seen;
      m_fl.push_back(t); m_pend = 0; m_seen = 0;
    end else if (e_req) begin
      m_pend = 1; m_pend_addr = e_addr;
      if (redir) m_seen = 1;
    end
    if (redir) begin
      m_pc = {rpc[63:2], 2'b00};
      foreach (m_fl[i]) m_fl[i].drop = 1;
    end
    had_buf = m_buf.size() > 0;
    if (flush_d) begin
      m_dv = 0; m_di = NOP;
    end else if (stall_d) begin
      m_dv = m_dv;
    end else if (had_buf && !redir) begin
      e = m_buf.pop_front();
      m_dv = 1; m_di = e.instr; m_dp = e.pc; m_dp4 = e.pc + 64'd4;
    end else if (got) begin
      m_dv = 1; m_di = g.instr; m_dp = g.pc; m_dp4 = g.pc + 64'd4;
    end else begin
      m_dv = 0; m_di = NOP;
    end
    if (got && (stall_d || flush_d)) m_buf.push_back(g);
    if (redir) m_buf.delete();
  endtask

  initial begin
    bit          seen_v;
    logic [63:0] exp_pc4;
    bit          mem_busy, fire;
    int          mem_cnt;
    logic [63:0] mem_addr, fire_addr;

    rstn = 0; stall_f = 0; stall_d = 0; flush_d = 0; redir = 0; rpc = '0;
    ready = 1; rsp_v = 0; rsp_d = '0;

    //             rdy rsp sd fd rd rpc        req addr      v pc         instr
    tbl[0]  = mk(1, 0, 0, 0, 0, 64'h0,   1, 64'h0,   0, 64'h0,   NOP);
    tbl[1]  = mk(0, 1, 0, 0, 0, 64'h0,   0, 64'h0,   0, 64'h0,   NOP);
    tbl[2]  = mk(1, 0, 0, 0, 0, 64'h0,   1, 64'h4,   1, 64'h0,   tag(1));
    tbl[3]  = mk(0, 1, 0, 0, 0, 64'h0,   0, 64'h0,   0, 64'h0,   NOP);
    tbl[4]  = mk(1, 0, 0, 0, 0, 64'h0,   1, 64'h8,   1, 64'h4,   tag(3));
    tbl[5]  = mk(0, 1, 1, 0, 0, 64'h0,   0, 64'h0,   0, 64'h4,   NOP);
    tbl[6]  = mk(1, 0, 1, 0, 0, 64'h0,   0, 64'h0,   0, 64'h4,   NOP);
    tbl[7]  = mk(1, 0, 1, 0, 0, 64'h0,   0, 64'h0,   0, 64'h4,   NOP);
    tbl[8]  = mk(1, 0, 1, 0, 0, 64'h0,   0, 64'h0,   0, 64'h4,   NOP);
    tbl[9]  = mk(1, 0, 0, 0, 0, 64'h0,   0, 64'h0,   0, 64'h4,   NOP);
    tbl[10] = mk(1, 0, 0, 0, 0, 64'h0,   1, 64'hC,   1, 64'h8,   tag(5));
    tbl[11] = mk(0, 1, 0, 0, 0, 64'h0,   0, 64'h0,   0, 64'h8,   NOP);
    tbl[12] = mk(1, 0, 0, 0, 0, 64'h0,   1, 64'h10,  1, 64'hC,   tag(11));
    tbl[13] = mk(0, 1, 0, 1, 1, 64'h100, 0, 64'h0,   0, 64'hC,   NOP);
    tbl[14] = mk(1, 0, 0, 0, 0, 64'h0,   1, 64'h100, 0, 64'hC,   NOP);
    tbl[15] = mk(0, 1, 0, 0, 0, 64'h0,   0, 64'h0,   0, 64'hC,   NOP);
    tbl[16] = mk(0, 0, 0, 1, 1, 64'h203, 1, 64'h104, 1, 64'h100, tag(15));
    tbl[17] = mk(0, 0, 0, 0, 0, 64'h0,   1, 64'h104, 0, 64'h100, NOP);
    tbl[18] = mk(0, 0, 0, 0, 0, 64'h0,   1, 64'h104, 0, 64'h100, NOP);
    tbl[19] = mk(1, 0, 0, 0, 0, 64'h0,   1, 64'h104, 0, 64'h100, NOP);
    tbl[20] = mk(0, 1, 0, 0, 0, 64'h0,   0, 64'h0,   0, 64'h100, NOP);
    tbl[21] = mk(1, 0, 0, 0, 0, 64'h0,   1, 64'h200, 0, 64'h100, NOP);
    tbl[22] = mk(0, 1, 1, 1, 0, 64'h0,   0, 64'h0,   0, 64'h100, NOP);
    tbl[23] = mk(0, 0, 0, 0, 0, 64'h0,   0, 64'h0,   0, 64'h100, NOP);
    tbl[24] = mk(0, 0, 0, 0, 0, 64'h0,   1, 64'h204, 1, 64'h200, tag(22));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_valid", 64'(req_v), 64'h0);
    chk("rst_b_req_valid", 64'(b_req), 64'h0);
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_instr", 64'(instr), 64'(NOP));
    chk("rst_pc", pc, 64'h0);
    chk("rst_pc4", pc4, 64'h0);
    rstn = 1;

    // Directed vector table
    seen_v = 0;
    for (int k = 0; k < 25; k++) begin
      if (tbl[k].exp_v) seen_v = 1;
      exp_pc4 = seen_v ? tbl[k].exp_pc + 64'd4 : 64'h0;
      chk($sformatf("vec%0d_valid", k), 64'(valid), 64'(tbl[k].exp_v));
      chk($sformatf("vec%0d_instr", k), 64'(instr), 64'(tbl[k].exp_instr));
      chk($sformatf("vec%0d_pc", k), pc, tbl[k].exp_pc);
      chk($sformatf("vec%0d_pc4", k), pc4, exp_pc4);
      ready = tbl[k].ready; rsp_v = tbl[k].rsp; rsp_d = tag(k);
      stall_d = tbl[k].sd; flush_d = tbl[k].fd; redir = tbl[k].rd; rpc = tbl[k].rpc;
      #1;
      chk($sformatf("vec%0d_req_valid", k), 64'(req_v), 64'(tbl[k].exp_req));
      if (tbl[k].exp_req) chk($sformatf("vec%0d_addr", k), addr, tbl[k].exp_addr);
      if (k == 0) chk("wrap_first_addr", b_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      if (k == 2) begin
        chk("wrap_pc", b_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_pc4", b_pc4, 64'h0);
        chk("wrap_second_addr", b_addr, 64'h0);
        chk("wrap_valid", 64'(b_valid), 64'h1);
      end
      @(negedge clk);
    end

    // Mid-operation reset: outstanding request aborted, late response ignored
    ready = 0; rsp_v = 0; stall_d = 0; flush_d = 0; redir = 0; rstn = 0;
    #1; chk("mr_req_in_reset", 64'(req_v), 64'h0);
    @(negedge clk);
    rstn = 1; ready = 1;
    #1; chk("mr_req1", 64'(req_v), 64'h1); chk("mr_addr1", addr, 64'h0);
    @(negedge clk);
    rstn = 0; ready = 0;
    #1; chk("mr_req_in_reset2", 64'(req_v), 64'h0);
    @(negedge clk);
    rstn = 1; rsp_v = 1; rsp_d = 32'hDEAD_BEEF;
    #1; chk("mr_req2", 64'(req_v), 64'h1); chk("mr_addr2", addr, 64'h0);
    @(negedge clk);
    chk("mr_late_rsp_valid", 64'(valid), 64'h0);
    rsp_v = 0; ready = 1;
    #1; chk("mr_req3", 64'(req_v), 64'h1);
    @(negedge clk);
    ready = 0; rsp_v = 1; rsp_d = 32'h1234_5678;
    @(negedge clk);
    rsp_v = 0;
    chk("mr_fetch_valid", 64'(valid), 64'h1);
    chk("mr_fetch_instr", 64'(instr), 64'h1234_5678);
    chk("mr_fetch_pc", pc, 64'h0);

    // Randomized run against the reference model
    rstn = 0;
    @(negedge clk);
    model_reset();
    mem_busy = 0; mem_cnt = 0; mem_addr = '0;
    rstn = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      chk($sformatf("rnd%0d_valid", cyc), 64'(valid), 64'(m_dv));
      chk($sformatf("rnd%0d_instr", cyc), 64'(instr), 64'(m_di));
      chk($sformatf("rnd%0d_pc", cyc), pc, m_dp);
      chk($sformatf("rnd%0d_pc4", cyc), pc4, m_dp4);
      rstn    = ($urandom_range(0, 299) != 0);
      stall_f = ($urandom_range(0, 3) == 0);
      stall_d = ($urandom_range(0, 3) == 0);
      redir   = ($urandom_range(0, 11) == 0);
      flush_d = redir || ($urandom_range(0, 9) == 0);
      rpc     = {$urandom, $urandom};
      rsp_v   = mem_busy && (mem_cnt == 0);
      rsp_d   = mem_data(mem_addr);
      ready   = !mem_busy && ($urandom_range(0, 3) != 0);
      #1;
      model_comb();
      chk($sformatf("rnd%0d_req_valid", cyc), 64'(req_v), 64'(e_req));
      if (e_req) chk($sformatf("rnd%0d_addr", cyc), addr, e_addr);
      fire = req_v && ready;
      fire_addr = addr;
      @(posedge clk);
      model_step();
      if (rsp_v) mem_busy = 0;
      else if (mem_busy && mem_cnt > 0) mem_cnt--;
      if (fire) begin
        mem_busy = 1; mem_cnt = $urandom_range(0, 3); mem_addr = fire_addr;
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
